// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg
//   Shared constants for the timer bank: register offsets within a channel
//   and in the global block, CTRL bit positions, channel stride, and a
//   helper that classifies the low address nibble as a channel register.
package timer_bank_pkg;

  localparam logic [31:0] CTRL_OFS     = 32'h0;
  localparam logic [31:0] PRESC_OFS    = 32'h4;
  localparam logic [31:0] CMP_OFS      = 32'h8;
  localparam logic [31:0] CNT_OFS      = 32'hC;
  localparam logic [31:0] IRQ_STAT_OFS = 32'h100;
  localparam logic [31:0] IRQ_EN_OFS   = 32'h104;
  localparam logic [31:0] CH_STRIDE    = 32'h10;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int PRESC_W       = 16;

  typedef enum logic [2:0] {
    REG_CTRL  = 3'd0,
    REG_PRESC = 3'd1,
    REG_CMP   = 3'd2,
    REG_CNT   = 3'd3,
    REG_NONE  = 3'd4
  } ch_reg_e;

  // Unaligned offsets inside a channel window map to no register.
  function automatic ch_reg_e ch_reg_of(input logic [3:0] lo);
    ch_reg_e r;
    case (lo)
      CTRL_OFS[3:0]:  r = REG_CTRL;
      PRESC_OFS[3:0]: r = REG_PRESC;
      CMP_OFS[3:0]:   r = REG_CMP;
      CNT_OFS[3:0]:   r = REG_CNT;
      default:        r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel
//   One timer channel: CTRL (EN, AUTO), 16-bit prescaler, compare and
//   counter registers plus the internal prescaler count.
// Ports
//   clk_i, rstn_i        clock, synchronous active-low reset
//   *_we_i               decoded full-word write strobes per register
//   wdata_i              CPU write data
//   match_o              one-cycle pulse on a tick where CNT == CMP
//   ctrl_o .. cnt_o      current register values for the read mux
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               ctrl_we_i,
  input  logic               presc_we_i,
  input  logic               cmp_we_i,
  input  logic               cnt_we_i,
  input  logic [31:0]        wdata_i,
  output logic               match_o,
  output logic [1:0]         ctrl_o,
  output logic [PRESC_W-1:0] presc_o,
  output logic [WIDTH-1:0]   cmp_o,
  output logic [WIDTH-1:0]   cnt_o
);

  localparam logic [WIDTH-1:0]   CNT_ONE = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PC_ONE  = PRESC_W'(1);

  logic [1:0]         ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]   cmp_q, cmp_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] pc_q, pc_d;

  logic en, auto_rl, tick;

  assign en      = ctrl_q[CTRL_EN_BIT];
  assign auto_rl = ctrl_q[CTRL_AUTO_BIT];
  assign tick    = en && (pc_q == presc_q);
  assign match_o = tick && (cnt_q == cmp_q);

  // CPU writes are applied last so they override the tick update.
  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;

    if (!en || tick) begin
      pc_d = '0;
    end else begin
      pc_d = pc_q + PC_ONE;
    end

    if (tick) begin
      cnt_d = match_o ? '0 : cnt_q + CNT_ONE;
    end

    if (match_o && !auto_rl) begin
      ctrl_d[CTRL_EN_BIT] = 1'b0;
    end

    // Any CTRL write restarts the prescaler so an enable always begins
    // a full prescale period.
    if (ctrl_we_i) begin
      ctrl_d = wdata_i[1:0];
      pc_d   = '0;
    end
    if (presc_we_i) begin
      presc_d = wdata_i[PRESC_W-1:0];
    end
    if (cmp_we_i) begin
      cmp_d = wdata_i[WIDTH-1:0];
    end
    if (cnt_we_i) begin
      cnt_d = wdata_i[WIDTH-1:0];
      pc_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      cmp_q   <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign presc_o = presc_q;
  assign cmp_o   = cmp_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/timer_bank.sv
// timer_bank
//   Memory-mapped bank of NUM_CH timer channels with a sticky interrupt
//   status register (W1C), an interrupt enable register and a registered
//   interrupt output. Reads are combinational.
// Ports
//   clk, rstn   clock, synchronous active-low reset
//   addr        CPU byte address
//   wdata       CPU write data
//   we          CPU byte enables; only a full-word write (4'hf) acts
//   rdata       read data, 0 outside the block
//   hit         addr decodes to a register of this block
//   irq         registered OR of IRQ_STAT & IRQ_EN
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h20100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  localparam logic [31:0] CH_SPAN = 32'(NUM_CH) * CH_STRIDE;

  logic [31:0] ofs;
  ch_reg_e     ch_reg;
  logic [3:0]  ch_sel;
  logic        ch_hit, stat_hit, en_hit, wr_full;

  assign ofs      = addr - BASE_ADDR;
  assign ch_reg   = ch_reg_of(ofs[3:0]);
  assign ch_sel   = ofs[7:4];
  assign ch_hit   = (ofs < CH_SPAN) && (ch_reg != REG_NONE);
  assign stat_hit = (ofs == IRQ_STAT_OFS);
  assign en_hit   = (ofs == IRQ_EN_OFS);
  assign hit      = ch_hit || stat_hit || en_hit;
  assign wr_full  = (we == 4'hf);

  logic [1:0]         ctrl_v  [NUM_CH];
  logic [PRESC_W-1:0] presc_v [NUM_CH];
  logic [WIDTH-1:0]   cmp_v   [NUM_CH];
  logic [WIDTH-1:0]   cnt_v   [NUM_CH];
  logic [NUM_CH-1:0]  match_v;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_full && ch_hit && (ch_sel == 4'(g));

    timer_channel #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .ctrl_we_i  (ch_wr && (ch_reg == REG_CTRL)),
      .presc_we_i (ch_wr && (ch_reg == REG_PRESC)),
      .cmp_we_i   (ch_wr && (ch_reg == REG_CMP)),
      .cnt_we_i   (ch_wr && (ch_reg == REG_CNT)),
      .wdata_i    (wdata),
      .match_o    (match_v[g]),
      .ctrl_o     (ctrl_v[g]),
      .presc_o    (presc_v[g]),
      .cmp_o      (cmp_v[g]),
      .cnt_o      (cnt_v[g])
    );
  end

  logic [NUM_CH-1:0] stat_q, stat_d;
  logic [NUM_CH-1:0] ien_q, ien_d;
  logic [NUM_CH-1:0] w1c_mask;
  logic              irq_q;

  // A match in the same cycle as a W1C of its bit wins: OR after clear.
  always_comb begin
    w1c_mask = (wr_full && stat_hit) ? wdata[NUM_CH-1:0] : '0;
    stat_d   = (stat_q & ~w1c_mask) | match_v;
    ien_d    = (wr_full && en_hit) ? wdata[NUM_CH-1:0] : ien_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_q <= '0;
      ien_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      ien_q  <= ien_d;
      irq_q  <= |(stat_q & ien_q);
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = '0;
    if (ch_hit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel == 4'(i)) begin
          case (ch_reg)
            REG_CTRL:  rdata = 32'(ctrl_v[i]);
            REG_PRESC: rdata = 32'(presc_v[i]);
            REG_CMP:   rdata = 32'(cmp_v[i]);
            REG_CNT:   rdata = 32'(cnt_v[i]);
            default:   rdata = '0;
          endcase
        end
      end
    end else if (stat_hit) begin
      rdata = 32'(stat_q);
    end else if (en_hit) begin
      rdata = 32'(ien_q);
    end
  end

endmodule
